// File: rtl/fwd_sel_pipe.sv
// -----------------------------------------------------------------------------
// fwd_sel_pipe
//   N-way operand-forwarding selector followed by a STAGES-deep register
//   pipeline. Each stage carries data, a valid bit and an error tag. The tag
//   marks a beat whose select was out of range. Out-of-range selects that are
//   actually accepted also set a sticky flag and bump a saturating 8-bit
//   counter for debug.
//
// Parameters
//   WIDTH   data width of each input and of the result
//   NUM_IN  number of selectable inputs (2..16)
//   STAGES  register stages between select and output (1..4)
//   SEL_W   derived select width, not meant to be overridden
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    packed inputs, input k at [k*WIDTH +: WIDTH]
//   select     input index
//   valid_in   select/in_data meaningful this cycle
//   stall      hold every stage
//   flush      zero every stage (takes precedence over stall)
//   err_clr    clear the sticky sel_err flag
//   result     last-stage data
//   valid_out  last-stage valid
//   err_out    last-stage error tag (aligned with result)
//   sel_err    sticky: an out-of-range select was accepted
//   err_count  saturating count of accepted out-of-range selects
// -----------------------------------------------------------------------------
module fwd_sel_pipe #(
  parameter  int WIDTH  = 64,
  parameter  int NUM_IN = 3,
  parameter  int STAGES = 1,
  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        select,
  input  logic                    valid_in,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        result,
  output logic                    valid_out,
  output logic                    err_out,
  output logic                    sel_err,
  output logic [7:0]              err_count
);

  // One extra bit so NUM_IN itself is representable; with a power-of-two
  // NUM_IN the compare below folds to constant false.
  localparam logic [SEL_W:0] LP_NUM_IN = (SEL_W + 1)'(NUM_IN);

  logic [WIDTH-1:0] r_data  [STAGES];
  logic             r_valid [STAGES];
  logic             r_err   [STAGES];

  logic             r_sel_err;
  logic [7:0]       r_err_count;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_oor;
  logic             w_acc_err;

  assign w_oor     = ({1'b0, select} >= LP_NUM_IN);
  assign w_acc_err = valid_in & ~stall & ~flush & w_oor;

  // Input mux. An out-of-range select matches no arm and leaves data at zero.
  always_comb begin
    // NOTE: default first so every path assigns w_sel_data; no latch inferred.
    w_sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (select == SEL_W'(k)) w_sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Pipeline: all stages share one stall/flush decision, so a beat never
  // duplicates or drops while the pipe is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the stage array is a handful of flops, not a RAM, so it is reset
      // explicitly; valid_out must drop the instant rst_n falls.
      for (int i = 0; i < STAGES; i++) begin
        r_data[i]  <= '0;
        r_valid[i] <= 1'b0;
        r_err[i]   <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        r_data[i]  <= '0;
        r_valid[i] <= 1'b0;
        r_err[i]   <= 1'b0;
      end
    end else if (!stall) begin
      // NOTE: non-blocking assignments make every stage read its neighbour's
      // old value, giving a true shift rather than a fall-through.
      r_data[0]  <= w_sel_data;
      r_valid[0] <= valid_in;
      r_err[0]   <= valid_in & w_oor;
      for (int i = 1; i < STAGES; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
        r_err[i]   <= r_err[i-1];
      end
    end
  end

  // Debug accounting. A set on the same edge as err_clr wins; the counter is
  // only cleared by reset and sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err   <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      if (w_acc_err)    r_sel_err <= 1'b1;
      else if (err_clr) r_sel_err <= 1'b0;
      if (w_acc_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign result    = r_data[STAGES-1];
  assign valid_out = r_valid[STAGES-1];
  assign err_out   = r_err[STAGES-1];
  assign sel_err   = r_sel_err;
  assign err_count = r_err_count;

endmodule

// File: doc/fwd_sel_pipe.md
Name: fwd_sel_pipe

Overview:
Parametrised N-way operand-forwarding selector with a configurable registered pipeline. It is the successor to the combinational 3-way 64-bit operand mux in the execute stage. It adds registered stages, stall/flush control and a per-result error tag in place of the undriven output. It also flags out-of-range selects through a sticky error bit and a saturating error counter for debug.

Parameters:
WIDTH, 64, data width of each input and the result
NUM_IN, 3, number of selectable inputs (2..16)
STAGES, 1, number of register stages between input select and output (1..4)
SEL_W, $clog2(NUM_IN) (min 1), select width; derived, must not be overridden

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
in_data  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
select  in  SEL_W  input index
valid_in  in  1  select/in_data are meaningful this cycle
stall  in  1  hold all pipeline stages
flush  in  1  invalidate all pipeline stages
err_clr  in  1  clear sticky error flag
result  out  WIDTH  selected data after STAGES cycles
valid_out  out  1  result is valid
err_out  out  1  result came from an out-of-range select (aligned with result)
sel_err  out  1  sticky: an out-of-range select was accepted
err_count  out  8  count of accepted out-of-range selects, saturating

Behaviour:
- Reset (rst_n low, async): every stage's data, valid and err bits = 0; result = 0, valid_out = 0, err_out = 0, sel_err = 0, err_count = 0. Release is synchronous to clk.
- Stage 0 capture (per rising edge):
  - stall=0, flush=0: valid0 <= valid_in.
  - If select < NUM_IN: data0 <= input[select], err0 <= 0.
  - Otherwise: data0 <= 0, err0 <= valid_in.
  - data0 captures even when valid_in=0; it is don't-care downstream.
- Stage i (1..STAGES-1): copies stage i-1 under the same stall/flush rules.
- result/valid_out/err_out are driven directly from the last stage registers; no combinational path from inputs.
- Latency: exactly STAGES clock edges from an accepted input to valid_out, absent stall.
- stall=1, flush=0: all stages hold data, valid and err; inputs are ignored; no error accounting.
- flush=1, with or without stall (flush wins): all valid and err bits <= 0 and all data <= 0. The input presented that cycle is discarded and not counted.
- Accepted error = valid_in & ~stall & ~flush & (select >= NUM_IN).
  - Sets sel_err on the next edge.
  - Increments err_count, which saturates at 255 and never wraps.
- err_clr=1 clears sel_err only; err_count is cleared only by reset.
  - err_clr coincident with an accepted error: set wins, so sel_err stays 1.
- NUM_IN a power of two: out-of-range is impossible; sel_err and err_count stay 0.
- Reset asserted mid-stream: pipeline contents are lost immediately; valid_out drops asynchronously.

Test Plan:
- Reset/latency (NUM_IN=3, STAGES=2): hold rst_n=0 → all outputs 0. Release; drive inputs 0x11/0x22/0x33 with valid_in=1, select 0,1,2 on consecutive cycles → result 0x11, 0x22, 0x33 with valid_out=1 on cycles 2, 3, 4 after the first drive.
- Out-of-range: select=3, valid_in=1 for one cycle → after 2 cycles result=0, valid_out=1, err_out=1; sel_err=1 and err_count=1 one edge after acceptance. Pulse err_clr → sel_err=0, err_count stays 1.
- Stall: issue 0xA then 0xB; assert stall for 3 cycles while 0xA is in stage 1 → result frozen for 3 cycles, then 0xA and 0xB emerge in order with no duplicate or lost beats. An out-of-range select during stall is not counted.
- Flush precedence: fill both stages with valid data; assert stall=1, flush=1 with select=3 → next edge valid_out=0, result=0, err_count unchanged.
- Saturation/race: 300 accepted out-of-range selects → err_count=255. Apply err_clr on the same edge as an error → sel_err remains 1.
- Async reset mid-stream: rst_n low between clock edges with valid data in flight → valid_out=0 and result=0 before the next edge.
